// File: rtl/pyfive_wb_uart.sv
// pyfive_wb_uart_fifo: small synchronous FIFO used for the UART TX and RX byte queues.
// Latency: a pushed entry is visible at dout/!empty the cycle after the push.
// Backpressure: pushes while full are dropped unless a pop happens in the same cycle.
module pyfive_wb_uart_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two; count separates full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; empty masks stale contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// pyfive_wb_uart: Wishbone B4 classic slave 8N1 UART with TX/RX FIFOs and a level interrupt.
// Latency: ack one cycle after cyc&stb; a TX frame starts the cycle after the TX FIFO goes non-empty.
// Backpressure: bus never stalls; TX writes into a full FIFO and RX bytes into a full FIFO are dropped.
module pyfive_wb_uart #(
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

    logic [15:0] div, eff_div;
    logic [1:0]  ie, reg_sel;
    logic        rx_overrun, frame_err;
    logic        wr_ack, rd_ack, tx_push, rx_pop, sts_wr;
    logic [7:0]  tx_head, rx_head;
    logic        tx_full, tx_empty, rx_full, rx_empty, rx_valid, tx_idle;
    logic [31:0] rdata;
    logic        unused_bits;

    assign unused_bits = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:16]};
    assign reg_sel  = wbs_adr_i[3:2];
    assign wr_ack   = wbs_ack_o && wbs_we_i;
    assign rd_ack   = wbs_ack_o && !wbs_we_i;
    assign tx_push  = wr_ack && (reg_sel == 2'd0) && wbs_sel_i[0];
    assign sts_wr   = wr_ack && (reg_sel == 2'd1);
    assign rx_pop   = rd_ack && (reg_sel == 2'd0) && !rx_empty;
    assign rx_valid = !rx_empty;
    assign eff_div  = (div < 16'd4) ? 16'd4 : div;

    // ---------------- TX path ----------------
    tx_state_t   tx_state, tx_state_n;
    logic [15:0] tx_cnt, tx_cnt_n, tx_div, tx_div_n;
    logic [2:0]  tx_bit, tx_bit_n;
    logic [7:0]  tx_shift, tx_shift_n;
    logic        tx_line_n, tx_pop, tx_load, tx_done;

    assign tx_done = (tx_cnt == tx_div - 16'd1);
    assign tx_idle = tx_empty && (tx_state == TX_IDLE);

    // TX next state: bit timing from the divider latched at frame start; STOP chains straight into START.
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + 16'd1;
        tx_div_n   = tx_div;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_line_n  = uart_tx;
        tx_pop     = 1'b0;
        tx_load    = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_n  = '0;
                tx_line_n = 1'b1;
                tx_load   = !tx_empty;
            end
            TX_START: if (tx_done) begin
                tx_cnt_n   = '0;
                tx_bit_n   = '0;
                tx_line_n  = tx_shift[0];
                tx_state_n = TX_DATA;
            end
            TX_DATA: if (tx_done) begin
                tx_cnt_n = '0;
                if (tx_bit == 3'd7) begin
                    tx_line_n  = 1'b1;
                    tx_state_n = TX_STOP;
                end else begin
                    tx_bit_n   = tx_bit + 3'd1;
                    tx_shift_n = {1'b0, tx_shift[7:1]};
                    tx_line_n  = tx_shift[1];
                end
            end
            TX_STOP: if (tx_done) begin
                tx_cnt_n   = '0;
                tx_line_n  = 1'b1;
                tx_state_n = TX_IDLE;
                tx_load    = !tx_empty;
            end
            default: tx_state_n = TX_IDLE;
        endcase
        if (tx_load) begin
            tx_pop     = 1'b1;
            tx_shift_n = tx_head;
            tx_div_n   = eff_div;
            tx_cnt_n   = '0;
            tx_line_n  = 1'b0;
            tx_state_n = TX_START;
        end
    end

    // TX state register; reset forces the line high immediately.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_div   <= DEFAULT_DIV;
            tx_bit   <= '0;
            tx_shift <= '0;
            uart_tx  <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_div   <= tx_div_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            uart_tx  <= tx_line_n;
        end
    end

    // ---------------- RX path ----------------
    rx_state_t   rx_state, rx_state_n;
    logic [1:0]  rx_sync;
    logic        rx_prev, rx_s, rx_push, rx_ferr;
    logic [15:0] rx_cnt, rx_cnt_n, rx_div, rx_div_n;
    logic [2:0]  rx_bit, rx_bit_n;
    logic [7:0]  rx_shift, rx_shift_n;

    assign rx_s = rx_sync[1];

    // RX next state: start confirmed at half a bit, then one sample per bit period.
    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + 16'd1;
        rx_div_n   = rx_div;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_push    = 1'b0;
        rx_ferr    = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = '0;
                if (rx_prev && !rx_s) begin
                    rx_div_n   = eff_div;
                    rx_state_n = RX_START;
                end
            end
            RX_START: if (rx_cnt == {1'b0, rx_div[15:1]} - 16'd1) begin
                rx_cnt_n   = '0;
                rx_bit_n   = '0;
                rx_state_n = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt == rx_div - 16'd1) begin
                rx_cnt_n   = '0;
                rx_shift_n = {rx_s, rx_shift[7:1]};
                rx_bit_n   = rx_bit + 3'd1;
                if (rx_bit == 3'd7) rx_state_n = RX_STOP;
            end
            RX_STOP: if (rx_cnt == rx_div - 16'd1) begin
                rx_cnt_n = '0;
                if (rx_s) begin
                    rx_push    = 1'b1;
                    rx_state_n = RX_IDLE;
                end else begin
                    rx_ferr    = 1'b1;
                    rx_state_n = RX_WAIT;
                end
            end
            RX_WAIT: begin
                rx_cnt_n = '0;
                if (rx_s) rx_state_n = RX_IDLE;
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // RX synchronizer and state register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            rx_sync  <= 2'b11;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_div   <= DEFAULT_DIV;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_sync  <= {rx_sync[0], uart_rx};
            rx_prev  <= rx_s;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_div   <= rx_div_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
        end
    end

    pyfive_wb_uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
        .clk(wb_clk_i), .rst_n(wb_rst_n), .push(tx_push), .pop(tx_pop),
        .din(wbs_dat_i[7:0]), .dout(tx_head), .full(tx_full), .empty(tx_empty)
    );

    pyfive_wb_uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
        .clk(wb_clk_i), .rst_n(wb_rst_n), .push(rx_push), .pop(rx_pop),
        .din(rx_shift), .dout(rx_head), .full(rx_full), .empty(rx_empty)
    );

    // ---------------- Bus side ----------------
    // Single-cycle ack, writes and sticky flags; a new error beats a same-cycle clear.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wbs_ack_o  <= 1'b0;
            div        <= DEFAULT_DIV;
            ie         <= '0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
            irq        <= 1'b0;
        end else begin
            wbs_ack_o <= wbs_cyc_i && wbs_stb_i && !wbs_ack_o;
            if (wr_ack && reg_sel == 2'd2) begin
                if (wbs_sel_i[0]) div[7:0]  <= wbs_dat_i[7:0];
                if (wbs_sel_i[1]) div[15:8] <= wbs_dat_i[15:8];
            end
            if (wr_ack && reg_sel == 2'd3) ie <= wbs_dat_i[1:0];
            if (rx_push && rx_full && !rx_pop) rx_overrun <= 1'b1;
            else if (sts_wr && wbs_dat_i[3])   rx_overrun <= 1'b0;
            if (rx_ferr)                       frame_err  <= 1'b1;
            else if (sts_wr && wbs_dat_i[4])   frame_err  <= 1'b0;
            irq <= (ie[0] && rx_valid) || (ie[1] && tx_idle);
        end
    end

    // Read mux; data bus is forced to zero outside the ack cycle.
    always_comb begin
        rdata = '0;
        case (reg_sel)
            2'd0: rdata = rx_valid ? {24'd0, rx_head} : 32'd0;
            2'd1: rdata = {27'd0, frame_err, rx_overrun, tx_idle, tx_full, rx_valid};
            2'd2: rdata = {16'd0, div};
            default: rdata = {30'd0, ie};
        endcase
        wbs_dat_o = wbs_ack_o ? rdata : 32'd0;
    end
endmodule

// File: tb/tb_pyfive_wb_uart.sv
// tb_pyfive_wb_uart: directed self-checking bench for the Wishbone UART.
// Latency: checks ack timing, TX frame start and irq update cycles.
// Backpressure: exercises TX FIFO overflow drop and RX overrun.
module tb_pyfive_wb_uart;
    logic        clk, rst_n, cyc, stb, we, ack, uart_rx, uart_tx, irq;
    logic [3:0]  sel;
    logic [31:0] adr, dat_w, dat_r;
    int total = 0;
    int bad = 0;

    pyfive_wb_uart #(.FIFO_DEPTH(4), .DEFAULT_DIV(16'd434)) dut (
        .wb_clk_i(clk), .wb_rst_n(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat_w),
        .wbs_ack_o(ack), .wbs_dat_o(dat_r), .uart_rx(uart_rx), .uart_tx(uart_tx), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wb_xfer(input logic w, input logic [1:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd);
        int n;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = {28'd0, a, 2'b00}; dat_w = d; sel = s;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack !== 1'b1 && n < 8);
        check("ack_latency", n, 1);
        rd = dat_r;
        @(negedge clk);
        check("ack_pulse", ack, 0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] x;
        wb_xfer(1'b1, a, d, 4'hF, x);
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] x;
        wb_xfer(1'b0, a, 32'd0, 4'hF, x);
        check(tag, x, exp);
    endtask

    task automatic wait_fall(input int maxwait, output int w);
        w = 0;
        while (w < maxwait) begin
            @(negedge clk);
            if (uart_tx === 1'b0) break;
            w++;
        end
    endtask

    task automatic get_frame(input string tag, input logic [7:0] exp, input int div,
                             input int maxwait, output int gap);
        logic       s [0:159];
        logic [9:0] v;
        int         nonuni;
        wait_fall(maxwait, gap);
        check({tag, "_started"}, 32'(gap < maxwait), 1);
        if (gap >= maxwait) return;
        s[0] = uart_tx;
        for (int i = 1; i < 10 * div; i++) begin
            @(negedge clk);
            s[i] = uart_tx;
        end
        nonuni = 0;
        for (int j = 0; j < 10; j++) begin
            v[j] = s[j * div];
            for (int k = 1; k < div; k++)
                if (s[j * div + k] !== v[j]) nonuni++;
        end
        check({tag, "_byte"}, v[8:1], exp);
        check({tag, "_framing"}, {v[0], v[9]}, 2'b01);
        check({tag, "_width"}, nonuni, 0);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stopb, input int div);
        logic [9:0] f;
        f = {stopb, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = f[i];
            repeat (div) @(negedge clk);
        end
        uart_rx = 1'b1;
    endtask

    initial begin
        logic [31:0] x;
        int gap;
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
        adr = '0; dat_w = '0; uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", uart_tx, 1);
        check("rst_irq", irq, 0);
        check("rst_ack", ack, 0);
        check("rst_dat", dat_r, 0);
        rst_n = 1'b1;
        rd_chk("rst_status", 2'd1, 32'h4);
        rd_chk("rst_div", 2'd2, 32'h1B2);
        check("rst_irq_after", irq, 0);
        check("dat_outside_ack", dat_r, 0);

        // DIV byte selects
        wb_xfer(1'b1, 2'd2, 32'h0000_55FF, 4'b0001, x);
        rd_chk("div_sel0", 2'd2, 32'h1FF);
        wb_xfer(1'b1, 2'd2, 32'h0000_0000, 4'b0010, x);
        rd_chk("div_sel1", 2'd2, 32'hFF);
        wr(2'd2, 32'd8);
        rd_chk("div8", 2'd2, 32'd8);

        // Single TX frame
        wr(2'd0, 32'hA5);
        get_frame("tx_a5", 8'hA5, 8, 20, gap);
        check("tx_a5_latency", gap, 0);
        rd_chk("tx_a5_idle", 2'd1, 32'h4);

        // TX FIFO overflow while busy; queued bytes run back to back
        wr(2'd0, 32'hFF);
        for (int i = 1; i <= 5; i++) wr(2'd0, i);
        rd_chk("tx_full_status", 2'd1, 32'h2);
        get_frame("tx_b1", 8'h01, 8, 200, gap);
        get_frame("tx_b2", 8'h02, 8, 8, gap);
        check("tx_b2_gap", gap, 0);
        get_frame("tx_b3", 8'h03, 8, 8, gap);
        check("tx_b3_gap", gap, 0);
        get_frame("tx_b4", 8'h04, 8, 8, gap);
        check("tx_b4_gap", gap, 0);
        wait_fall(100, gap);
        check("tx_drop5", gap, 100);
        rd_chk("tx_drain_idle", 2'd1, 32'h4);

        // DIV below 4 clamps to 4 bit width
        wr(2'd2, 32'd2);
        rd_chk("div2_raw", 2'd2, 32'd2);
        wr(2'd0, 32'h0F);
        get_frame("tx_clamp", 8'h0F, 4, 20, gap);
        check("tx_clamp_latency", gap, 0);
        wr(2'd2, 32'd8);

        // RX single byte with rx_valid interrupt
        wr(2'd3, 32'd1);
        check("irq_quiet", irq, 0);
        send_rx(8'h3C, 1'b1, 8);
        @(negedge clk);
        check("rx_irq_rise", irq, 1);
        rd_chk("rx_data", 2'd0, 32'h3C);
        check("rx_irq_hold", irq, 1);
        @(negedge clk);
        check("rx_irq_fall", irq, 0);
        rd_chk("rx_status_empty", 2'd1, 32'h4);
        rd_chk("rx_data_empty", 2'd0, 32'h0);

        // RX overrun
        for (int i = 0; i < 6; i++) send_rx(8'(8'h11 * (i + 1)), 1'b1, 8);
        repeat (4) @(negedge clk);
        rd_chk("ovr_status", 2'd1, 32'hD);
        wr(2'd1, 32'h8);
        rd_chk("ovr_cleared", 2'd1, 32'h5);
        for (int i = 0; i < 4; i++) rd_chk("ovr_keep", 2'd0, 32'(8'h11 * (i + 1)));
        rd_chk("ovr_empty", 2'd1, 32'h4);

        // Short low glitch is rejected
        uart_rx = 1'b0;
        repeat (2) @(negedge clk);
        uart_rx = 1'b1;
        repeat (40) @(negedge clk);
        rd_chk("glitch_none", 2'd1, 32'h4);

        // Framing error
        send_rx(8'h55, 1'b0, 8);
        repeat (4) @(negedge clk);
        rd_chk("ferr_status", 2'd1, 32'h14);
        wr(2'd1, 32'h10);
        rd_chk("ferr_cleared", 2'd1, 32'h4);

        // tx_idle interrupt
        wr(2'd3, 32'd2);
        @(negedge clk);
        check("irq_txidle", irq, 1);

        // Reset in the middle of a frame with another byte queued
        wr(2'd0, 32'h00);
        wr(2'd0, 32'h81);
        repeat (30) @(negedge clk);
        check("midtx_low", uart_tx, 0);
        rst_n = 1'b0;
        #1;
        check("rst_tx_async", uart_tx, 1);
        check("rst_irq_async", irq, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_chk("rst2_status", 2'd1, 32'h4);
        rd_chk("rst2_div", 2'd2, 32'h1B2);
        rd_chk("rst2_ie", 2'd3, 32'h0);
        wait_fall(100, gap);
        check("rst2_no_frame", gap, 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
